// File: rtl/symb_pkg.sv
// Shared constants and saturation bounds for the symmetric-pair subtractor.
package symb_pkg;

  localparam int SYMB_W    = 4;
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Largest signed value representable in w bits, returned wide so callers slice it.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/symb_sub_core.sv
// Combinational W+1-bit subtract of a_i - b_i with borrow/overflow flags and optional clamping.
module symb_sub_core
  import symb_pkg::*;
#(
  parameter int W   = SYMB_W,
  parameter int SAT = SAT_WRAP
) (
  input  logic [W-1:0]        a_i,
  input  logic [W-1:0]        b_i,
  output logic [W-1:0]        uns_o,
  output logic signed [W-1:0] sgn_o,
  output logic                borrow_o,
  output logic                ovf_o
);

  localparam logic signed [63:0] MAX64 = sat_max(W);
  localparam logic signed [63:0] MIN64 = sat_min(W);
  localparam logic [W-1:0]       S_MAX = MAX64[W-1:0];
  localparam logic [W-1:0]       S_MIN = MIN64[W-1:0];

  logic [W:0] diff_u;
  logic [W:0] diff_s;

  assign diff_u = {1'b0, a_i} - {1'b0, b_i};
  assign diff_s = {a_i[W-1], a_i} - {b_i[W-1], b_i};

  always_comb begin
    borrow_o = diff_u[W];
    // The extended sign disagreeing with bit W-1 is exactly "operand signs differ
    // and the result sign differs from the minuend".
    ovf_o    = diff_s[W] ^ diff_s[W-1];
    uns_o    = diff_u[W-1:0];
    sgn_o    = diff_s[W-1:0];
    if (SAT == SAT_CLAMP) begin
      if (diff_u[W]) uns_o = '0;
      if (ovf_o)     sgn_o = a_i[W-1] ? S_MIN : S_MAX;
    end
  end

endmodule

// File: rtl/symb_sub_pipe.sv
// Two-stage valid/ready pipeline around symb_sub_core: stage 1 holds operands, stage 2 holds results.
module symb_sub_pipe
  import symb_pkg::*;
#(
  parameter int W   = SYMB_W,
  parameter int SAT = SAT_WRAP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        d1,
  input  logic [W-1:0]        d2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        unsigned_out,
  output logic signed [W-1:0] signed_out,
  output logic                borrow,
  output logic                ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a stage only reloads when its contents are consumed or empty.
  logic                s1_v_q, s2_v_q;
  logic [W-1:0]        d1_q, d2_q;
  logic [W-1:0]        uns_q;
  logic signed [W-1:0] sgn_q;
  logic                borrow_q, ovf_q;

  logic                adv1, adv2;
  logic [W-1:0]        uns_d;
  logic signed [W-1:0] sgn_d;
  logic                borrow_d, ovf_d;

  assign adv2      = !s2_v_q || out_ready;
  assign adv1      = !s1_v_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_v_q;

  symb_sub_core #(.W(W), .SAT(SAT)) u_core (
    .a_i      (d1_q),
    .b_i      (d2_q),
    .uns_o    (uns_d),
    .sgn_o    (sgn_d),
    .borrow_o (borrow_d),
    .ovf_o    (ovf_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      d1_q   <= '0;
      d2_q   <= '0;
    end else if (adv1) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        d1_q <= d1;
        d2_q <= d2;
      end
    end
  end

  // Result registers only load from a valid stage 1, so an empty pipe keeps its last output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q   <= 1'b0;
      uns_q    <= '0;
      sgn_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (adv2) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        uns_q    <= uns_d;
        sgn_q    <= sgn_d;
        borrow_q <= borrow_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign unsigned_out = uns_q;
  assign signed_out   = sgn_q;
  assign borrow       = borrow_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_symb_sub_pipe.sv
// Scoreboard bench: wrap and clamp instances share stimulus; expected results come from an integer model.
module tb_symb_sub_pipe;

  localparam int W  = 4;
  localparam int EW = 4 * W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                in_valid, out_ready;
  logic [W-1:0]        d1, d2;
  logic                rdy_w, rdy_c, ov_w, ov_c;
  logic [W-1:0]        uo_w, uo_c;
  logic signed [W-1:0] so_w, so_c;
  logic                b_w, b_c, o_w, o_c;

  symb_sub_pipe #(.W(W), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w),
    .d1(d1), .d2(d2), .out_valid(ov_w), .out_ready(out_ready),
    .unsigned_out(uo_w), .signed_out(so_w), .borrow(b_w), .ovf(o_w)
  );

  symb_sub_pipe #(.W(W), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
    .d1(d1), .d2(d2), .out_valid(ov_c), .out_ready(out_ready),
    .unsigned_out(uo_c), .signed_out(so_c), .borrow(b_c), .ovf(o_c)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: plain integer arithmetic, then wrap or clamp into W bits.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, ud, sd, smax, smin;
    logic brw, ov;
    logic [W-1:0] uw, sw, uc, sc;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    ud = ua - ub;
    sd = sa - sb;
    brw = (ud < 0);
    ov  = (sd > smax) || (sd < smin);
    uw  = W'(ud);
    sw  = W'(sd);
    uc  = brw ? '0 : uw;
    sc  = (sd > smax) ? W'(smax) : (sd < smin) ? W'(smin) : sw;
    return {uw, sw, uc, sc, brw, ov};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    d1        = a;
    d2        = b;
    out_ready = ordy;
    #1;
    exp_rdy = ordy || (exp_q.size() < 2);
    check("in_ready_wrap", {31'b0, rdy_w}, {31'b0, exp_rdy});
    check("in_ready_sat",  {31'b0, rdy_c}, {31'b0, exp_rdy});
    acc = v && rdy_w;
    if (acc) exp_q.push_back(model(a, b));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, a, b, ordy, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) fail("send_timeout");
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cycle(1'b0, '0, '0, ordy, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  {31'b0, ov_w | ov_c}, 32'd0);
    check({tag, "_uns"},    {28'b0, uo_w | uo_c}, 32'd0);
    check({tag, "_sgn"},    {28'b0, $unsigned(so_w) | $unsigned(so_c)}, 32'd0);
    check({tag, "_flags"},  {30'b0, b_w | b_c, o_w | o_c}, 32'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && (ov_w || ov_c)) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = exp_q[0];
          check("out_valid_wrap", {31'b0, ov_w}, 32'd1);
          check("out_valid_sat",  {31'b0, ov_c}, 32'd1);
          check("uns_wrap",  {28'b0, uo_w}, {28'b0, e[EW-1 -: W]});
          check("sgn_wrap",  {28'b0, $unsigned(so_w)}, {28'b0, e[EW-1-W -: W]});
          check("uns_sat",   {28'b0, uo_c}, {28'b0, e[EW-1-2*W -: W]});
          check("sgn_sat",   {28'b0, $unsigned(so_c)}, {28'b0, e[EW-1-3*W -: W]});
          check("flags_wrap", {30'b0, b_w, o_w}, {30'b0, e[1:0]});
          check("flags_sat",  {30'b0, b_c, o_c}, {30'b0, e[1:0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d1 = '0; d2 = '0;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    #2 rst_n = 1'b1;

    // Latency from an empty pipe: result visible after two edges, consumed on the third.
    send(4'd3, 4'd5, 1'b1);
    idle(1'b1);
    check("lat_edge1", {31'b0, ov_w}, 32'd0);
    idle(1'b1);
    check("lat_edge2", {31'b0, ov_w}, 32'd1);
    drain();

    // Overflow / clamp corners.
    send(4'h7, 4'hF, 1'b1);
    send(4'h8, 4'h1, 1'b1);
    send(4'h0, 4'h8, 1'b1);
    send(4'hF, 4'hF, 1'b1);
    drain();

    // Streaming 0..15 minus 1 at full rate.
    for (int i = 0; i < 16; i++) send(W'(i), 4'd1, 1'b1);
    drain();

    // Backpressure: two accepts fill the pipe, further attempts stall, then release.
    send(4'd9, 4'd2, 1'b0);
    send(4'd2, 4'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'd12, 4'd4, 1'b0, acc);
      if (acc) fail("accepted_while_full");
    end
    send(4'd12, 4'd4, 1'b1);
    send(4'd5, 4'd13, 1'b1);
    drain();

    // Asynchronous reset with two pairs in flight.
    send(4'd3, 4'd5, 1'b0);
    send(4'h7, 4'hF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("post_reset_valid", {31'b0, ov_w | ov_c}, 32'd0);
    end

    // Random traffic with random gaps and backpressure.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0, acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
